// File: rtl/sd_cmd_ctrl.sv
// SD-over-SPI command engine: sends a 6-byte SD command frame through the spi byte
// engine, then polls for an R1 response. Optional macro SD_CRC7_EN builds a real CRC7.
module sd_cmd_ctrl #(
    parameter int NCR_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        cmd_busy,
    output logic        cmd_done,
    output logic [7:0]  resp_r1,
    output logic        resp_timeout,
    output logic [7:0]  spi_data_write,
    output logic        spi_write_en,
    output logic        spi_read_en,
    input  logic [7:0]  spi_data_read,
    input  logic        spi_write_busy,
    input  logic        spi_read_busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TX_ISSUE = 3'd1,
        S_TX_ARM   = 3'd2,
        S_TX_WAIT  = 3'd3,
        S_RX_ISSUE = 3'd4,
        S_RX_ARM   = 3'd5,
        S_RX_WAIT  = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    localparam logic [7:0] NCR_LIMIT = NCR_MAX[7:0];
    localparam logic [2:0] LAST_BYTE = 3'd5;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [5:0]  r_index;
    logic [31:0] r_arg;
    logic [2:0]  r_byte_cnt;
    logic [7:0]  r_poll_cnt;
    logic [7:0]  r_resp_r1;
    logic        r_resp_timeout;
    logic        r_cmd_busy;
    logic        r_cmd_done;
    logic [7:0]  r_data_write;
    logic        r_write_en;
    logic        r_read_en;

    logic [5:0]  w_index_nxt;
    logic [31:0] w_arg_nxt;
    logic [2:0]  w_byte_cnt_nxt;
    logic [7:0]  w_poll_cnt_nxt;
    logic [7:0]  w_resp_r1_nxt;
    logic        w_resp_timeout_nxt;
    logic [7:0]  w_data_write_nxt;

`ifdef SD_CRC7_EN
    // CRC7 (x^7 + x^3 + 1), zero seed, MSB-first over the 40 header bits.
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
        end
        return c;
    endfunction

    function automatic logic [7:0] crc_byte(input logic [39:0] hdr);
        return {crc7(hdr), 1'b1};
    endfunction
`else
    // Without CRC logic only the two commands legal before CRC is disabled carry a valid CRC.
    function automatic logic [7:0] crc_byte(input logic [5:0] idx);
        logic [7:0] b;
        case (idx)
            6'd0:    b = 8'h95;
            6'd8:    b = 8'h87;
            default: b = 8'hFF;
        endcase
        return b;
    endfunction
`endif

    function automatic logic [7:0] frame_byte(input logic [5:0] idx, input logic [31:0] arg,
                                              input logic [2:0] sel);
        logic [7:0] b;
        case (sel)
            3'd0:    b = {2'b01, idx};
            3'd1:    b = arg[31:24];
            3'd2:    b = arg[23:16];
            3'd3:    b = arg[15:8];
            3'd4:    b = arg[7:0];
`ifdef SD_CRC7_EN
            3'd5:    b = crc_byte({2'b01, idx, arg});
`else
            3'd5:    b = crc_byte(idx);
`endif
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_start) begin
                    w_state_nxt = S_TX_ISSUE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_TX_ISSUE: w_state_nxt = S_TX_ARM;
            S_TX_ARM:   w_state_nxt = S_TX_WAIT;
            S_TX_WAIT: begin
                if (spi_write_busy) begin
                    w_state_nxt = S_TX_WAIT;
                end else if (r_byte_cnt == LAST_BYTE) begin
                    w_state_nxt = S_RX_ISSUE;
                end else begin
                    w_state_nxt = S_TX_ISSUE;
                end
            end
            S_RX_ISSUE: w_state_nxt = S_RX_ARM;
            S_RX_ARM:   w_state_nxt = S_RX_WAIT;
            S_RX_WAIT: begin
                if (spi_read_busy) begin
                    w_state_nxt = S_RX_WAIT;
                end else if (!spi_data_read[7]) begin
                    w_state_nxt = S_DONE;
                end else if (r_poll_cnt == NCR_LIMIT) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RX_ISSUE;
                end
            end
            S_DONE:     w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Output and datapath next values; strobes are registered from the next state.
    always_comb begin
        w_index_nxt        = r_index;
        w_arg_nxt          = r_arg;
        w_byte_cnt_nxt     = r_byte_cnt;
        w_poll_cnt_nxt     = r_poll_cnt;
        w_resp_r1_nxt      = r_resp_r1;
        w_resp_timeout_nxt = r_resp_timeout;
        case (r_state)
            S_IDLE: begin
                if (cmd_start) begin
                    w_index_nxt        = cmd_index;
                    w_arg_nxt          = cmd_arg;
                    w_byte_cnt_nxt     = 3'd0;
                    w_poll_cnt_nxt     = 8'd0;
                    w_resp_r1_nxt      = 8'hFF;
                    w_resp_timeout_nxt = 1'b0;
                end else begin
                    w_index_nxt        = r_index;
                end
            end
            S_TX_WAIT: begin
                if (!spi_write_busy && (r_byte_cnt != LAST_BYTE)) begin
                    w_byte_cnt_nxt = r_byte_cnt + 3'd1;
                end else begin
                    w_byte_cnt_nxt = r_byte_cnt;
                end
            end
            S_RX_ISSUE: begin
                w_poll_cnt_nxt = r_poll_cnt + 8'd1;
            end
            S_RX_WAIT: begin
                if (!spi_read_busy) begin
                    w_resp_r1_nxt = spi_data_read;
                    if (spi_data_read[7] && (r_poll_cnt == NCR_LIMIT)) begin
                        w_resp_timeout_nxt = 1'b1;
                    end else begin
                        w_resp_timeout_nxt = r_resp_timeout;
                    end
                end else begin
                    w_resp_r1_nxt = r_resp_r1;
                end
            end
            default: begin
                w_poll_cnt_nxt = r_poll_cnt;
            end
        endcase
        // The byte is selected from next-cycle values so B0 is ready in the first issue cycle.
        if (w_state_nxt == S_TX_ISSUE) begin
            w_data_write_nxt = frame_byte(w_index_nxt, w_arg_nxt, w_byte_cnt_nxt);
        end else begin
            w_data_write_nxt = r_data_write;
        end
    end

    // Registered datapath and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_index        <= 6'd0;
            r_arg          <= 32'd0;
            r_byte_cnt     <= 3'd0;
            r_poll_cnt     <= 8'd0;
            r_resp_r1      <= 8'hFF;
            r_resp_timeout <= 1'b0;
            r_cmd_busy     <= 1'b0;
            r_cmd_done     <= 1'b0;
            r_data_write   <= 8'hFF;
            r_write_en     <= 1'b0;
            r_read_en      <= 1'b0;
        end else begin
            r_index        <= w_index_nxt;
            r_arg          <= w_arg_nxt;
            r_byte_cnt     <= w_byte_cnt_nxt;
            r_poll_cnt     <= w_poll_cnt_nxt;
            r_resp_r1      <= w_resp_r1_nxt;
            r_resp_timeout <= w_resp_timeout_nxt;
            r_cmd_busy     <= (w_state_nxt != S_IDLE);
            r_cmd_done     <= (w_state_nxt == S_DONE);
            r_data_write   <= w_data_write_nxt;
            r_write_en     <= (w_state_nxt == S_TX_ISSUE);
            r_read_en      <= (w_state_nxt == S_RX_ISSUE);
        end
    end

    assign cmd_busy       = r_cmd_busy;
    assign cmd_done       = r_cmd_done;
    assign resp_r1        = r_resp_r1;
    assign resp_timeout   = r_resp_timeout;
    assign spi_data_write = r_data_write;
    assign spi_write_en   = r_write_en;
    assign spi_read_en    = r_read_en;

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Directed scoreboard bench for sd_cmd_ctrl with a behavioural spi byte-engine responder.
module tb_sd_cmd_ctrl;

    localparam int NCR = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_start = 1'b0;
    logic [5:0]  cmd_index = 6'd0;
    logic [31:0] cmd_arg = 32'd0;
    logic        cmd_busy, cmd_done, resp_timeout;
    logic [7:0]  resp_r1, spi_data_write;
    logic        spi_write_en, spi_read_en;
    logic [7:0]  spi_data_read = 8'hFF;
    logic        spi_write_busy = 1'b0;
    logic        spi_read_busy = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int n_wr = 0, n_rd = 0, n_done = 0, n_extra = 0, n_both = 0;
    int wcnt = 0, rcnt = 0;
    int tw = 3, tr = 2;
    logic [7:0] exp_q[$];
    logic [7:0] miso_q[$];

    sd_cmd_ctrl #(.NCR_MAX(NCR)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_index(cmd_index),
        .cmd_arg(cmd_arg), .cmd_busy(cmd_busy), .cmd_done(cmd_done), .resp_r1(resp_r1),
        .resp_timeout(resp_timeout), .spi_data_write(spi_data_write),
        .spi_write_en(spi_write_en), .spi_read_en(spi_read_en),
        .spi_data_read(spi_data_read), .spi_write_busy(spi_write_busy),
        .spi_read_busy(spi_read_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

`ifdef SD_CRC7_EN
    function automatic logic [7:0] tb_crc(input logic [39:0] m);
        logic [6:0] c;
        logic       b;
        c = 7'd0;
        for (int i = 0; i < 40; i++) begin
            b    = m[39-i] ^ c[6];
            c    = c << 1;
            c[0] = b;
            c[3] = c[3] ^ b;
        end
        return {c, 1'b1};
    endfunction
`endif

    function automatic logic [7:0] exp_b5(input logic [5:0] idx, input logic [31:0] arg);
`ifdef SD_CRC7_EN
        return tb_crc({2'b01, idx, arg});
`else
        if (idx == 6'd0) return 8'h95;
        else if (idx == 6'd8) return 8'h87;
        else return 8'hFF + 8'h00 * arg[7:0];
`endif
    endfunction

    // Byte-engine responder: busy rises after each enable and scoreboard checks written bytes.
    initial begin
        forever begin
            @(negedge clk);
            if (spi_write_en && spi_read_en) n_both++;
            if (cmd_done) n_done++;
            if (spi_write_en) begin
                n_wr++;
                wcnt = tw;
                if (exp_q.size() > 0) check("tx_byte", spi_data_write, exp_q.pop_front());
                else n_extra++;
            end else if (wcnt > 0) begin
                wcnt--;
            end
            spi_write_busy = (wcnt != 0);
            if (spi_read_en) begin
                n_rd++;
                rcnt = tr;
                spi_data_read = (miso_q.size() > 0) ? miso_q.pop_front() : 8'hFF;
            end else if (rcnt > 0) begin
                rcnt--;
            end
            spi_read_busy = (rcnt != 0);
        end
    end

    task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg);
        exp_q.push_back({2'b01, idx});
        exp_q.push_back(arg[31:24]);
        exp_q.push_back(arg[23:16]);
        exp_q.push_back(arg[15:8]);
        exp_q.push_back(arg[7:0]);
        exp_q.push_back(exp_b5(idx, arg));
        @(negedge clk);
        cmd_start = 1'b1;
        cmd_index = idx;
        cmd_arg   = arg;
        @(negedge clk);
        cmd_start = 1'b0;
        cmd_index = 6'h3F;
        cmd_arg   = 32'hDEADBEEF;
        check("busy_after_accept", cmd_busy, 1'b1);
        check("first_wen_latency", spi_write_en, 1'b1);
    endtask

    task automatic finish_cmd(input int rd0, input logic [7:0] r1, input logic to, input int reads);
        int done0;
        for (int i = 0; i < 3000 && !cmd_done; i++) @(negedge clk);
        check("done_seen", cmd_done, 1'b1);
        done0 = n_done;
        check("resp_r1", resp_r1, r1);
        check("resp_timeout", resp_timeout, to);
        check("read_count", n_rd - rd0, reads);
        check("frame_complete", exp_q.size(), 0);
        // A start in the DONE cycle must be ignored.
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        check("done_one_cycle", cmd_done, 1'b0);
        check("busy_drop", cmd_busy, 1'b0);
        check("r1_held", resp_r1, r1);
        repeat (4) @(negedge clk);
        check("start_in_done_ignored", cmd_busy, 1'b0);
        check("single_done_pulse", n_done - done0, 0);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int rd0, wr0, done0;
        repeat (3) @(negedge clk);
        check("rst_busy", cmd_busy, 1'b0);
        check("rst_done", cmd_done, 1'b0);
        check("rst_r1", resp_r1, 8'hFF);
        check("rst_to", resp_timeout, 1'b0);
        check("rst_dw", spi_data_write, 8'hFF);
        check("rst_wen", spi_write_en, 1'b0);
        check("rst_ren", spi_read_en, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // CMD0, response after two idle bytes.
        miso_q = '{8'hFF, 8'hFF, 8'h01};
        rd0 = n_rd;
        start_cmd(6'd0, 32'h0000_0000);
        finish_cmd(rd0, 8'h01, 1'b0, 3);

        // CMD8, immediate response.
        miso_q = '{8'h01};
        rd0 = n_rd;
        start_cmd(6'd8, 32'h0000_01AA);
        finish_cmd(rd0, 8'h01, 1'b0, 1);

        // CMD17: CRC byte depends on build configuration.
        miso_q = '{8'h00};
        rd0 = n_rd;
        start_cmd(6'd17, 32'h0000_0000);
        finish_cmd(rd0, 8'h00, 1'b0, 1);

        // MISO stuck high: poll limit timeout.
        miso_q.delete();
        rd0 = n_rd;
        start_cmd(6'd55, 32'h1234_5678);
        finish_cmd(rd0, 8'hFF, 1'b1, NCR);

        // Zero-latency engine: no stall cycles.
        tw = 0;
        tr = 0;
        miso_q = '{8'hFE, 8'h05};
        rd0 = n_rd;
        start_cmd(6'd41, 32'h4000_0000);
        finish_cmd(rd0, 8'h05, 1'b0, 2);
        tw = 3;
        tr = 2;

        // cmd_start during TX_WAIT of byte 2 is ignored.
        miso_q = '{8'h00};
        rd0 = n_rd;
        start_cmd(6'd24, 32'hA5A5_0F0F);
        for (int i = 0; i < 200 && n_wr - (0) >= 0 && exp_q.size() > 3; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        cmd_start = 1'b1;
        cmd_index = 6'd1;
        cmd_arg   = 32'hFFFF_FFFF;
        @(negedge clk);
        cmd_start = 1'b0;
        finish_cmd(rd0, 8'h00, 1'b0, 1);

        // Reset during RX_WAIT aborts without cmd_done.
        tr = 6;
        miso_q.delete();
        rd0 = n_rd;
        start_cmd(6'd0, 32'h0000_0000);
        for (int i = 0; i < 400 && n_rd == rd0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("tx_done_before_reset", exp_q.size(), 0);
        done0 = n_done;
        rst_n = 1'b0;
        #1;
        check("abort_busy", cmd_busy, 1'b0);
        check("abort_done", cmd_done, 1'b0);
        check("abort_r1", resp_r1, 8'hFF);
        check("abort_to", resp_timeout, 1'b0);
        check("abort_dw", spi_data_write, 8'hFF);
        check("abort_wen", spi_write_en, 1'b0);
        check("abort_ren", spi_read_en, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wr0 = n_wr;
        repeat (20) @(negedge clk);
        check("no_done_after_abort", n_done - done0, 0);
        check("idle_after_abort", n_wr - wr0, 0);

        check("extra_writes", n_extra, 0);
        check("wen_ren_overlap", n_both, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
